// File: rtl/div_sched.sv
// div_sched: round-robin front end that shares one multi-cycle divider among
// NREQ requesters. One operation is in flight at a time. Each requester offers
// a dividend/divisor pair on a valid/ready channel. The result returns on a single
// response channel, tagged with the owning requester's index.
//
// Ports
//   clk, rst_n               clock; synchronous active-low reset (shared with divider)
//   req_valid / req_ready    per-requester handshake; ready is one-hot or zero
//   req_a / req_b            packed operands, requester k at [k*N +: N]
//   rsp_valid / rsp_ready    result handshake
//   rsp_id/rsp_quot/rsp_rem  held stable while rsp_valid is high
//   div_en                   one-cycle divider start pulse
//   div_a / div_b            operands of the granted request
//   div_done                 divider completion strobe (honoured only while waiting)
//   div_quot / div_rem       divider result, forwarded unchanged
//
// Configuration macro: DIV_SCHED_DIVZERO_BYPASS_EN
//   When defined, a request with b == 0 does not use the divider. It answers on
//   the next cycle with quot = all ones and rem = a.
module div_sched #(
  parameter int N    = 21,
  parameter int NREQ = 2,
  parameter int ID_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic [N-1:0]      rsp_quot,
  output logic [N-1:0]      rsp_rem,
  output logic              div_en,
  output logic [N-1:0]      div_a,
  output logic [N-1:0]      div_b,
  input  logic              div_done,
  input  logic [N-1:0]      div_quot,
  input  logic [N-1:0]      div_rem
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [N-1:0]    a_q, a_d, b_q, b_d;
  logic [N-1:0]    quot_q, quot_d, rem_q, rem_d;

  logic            hi_found_s, lo_found_s, gnt_found_s;
  logic [PW-1:0]   hi_idx_s, lo_idx_s, gnt_idx_s;
  logic [N-1:0]    gnt_a_s, gnt_b_s;

  // Round-robin pick: search from ptr upwards first. If nothing is found there,
  // the lowest valid index overall lies below ptr, which completes the wrap.
  always_comb begin
    hi_found_s = 1'b0;
    hi_idx_s   = '0;
    lo_found_s = 1'b0;
    lo_idx_s   = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!hi_found_s && req_valid[j] && (j >= int'(ptr_q))) begin
        hi_found_s = 1'b1;
        hi_idx_s   = PW'(j);
      end else begin
        hi_found_s = hi_found_s;
      end
      if (!lo_found_s && req_valid[j]) begin
        lo_found_s = 1'b1;
        lo_idx_s   = PW'(j);
      end else begin
        lo_found_s = lo_found_s;
      end
    end
    gnt_found_s = hi_found_s | lo_found_s;
    gnt_idx_s   = hi_found_s ? hi_idx_s : lo_idx_s;
  end

  // Operand mux for the granted requester (constant part-selects only).
  always_comb begin
    gnt_a_s = {N{1'b0}};
    gnt_b_s = {N{1'b0}};
    for (int j = 0; j < NREQ; j++) begin
      if (gnt_idx_s == PW'(j)) begin
        gnt_a_s = req_a[j*N +: N];
        gnt_b_s = req_b[j*N +: N];
      end else begin
        gnt_a_s = gnt_a_s;
      end
    end
  end

  // Grant is offered only in IDLE and never while reset is asserted.
  always_comb begin
    req_ready = '0;
    if ((state_q == S_IDLE) && gnt_found_s && rst_n) begin
      req_ready = {{(NREQ-1){1'b0}}, 1'b1} << gnt_idx_s;
    end else begin
      req_ready = '0;
    end
  end

  // Next-state and datapath-capture logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_found_s) begin
          a_d   = gnt_a_s;
          b_d   = gnt_b_s;
          id_d  = ID_W'(gnt_idx_s);
          ptr_d = (gnt_idx_s == PW'(NREQ-1)) ? {PW{1'b0}} : gnt_idx_s + PW'(1);
`ifdef DIV_SCHED_DIVZERO_BYPASS_EN
          if (gnt_b_s == {N{1'b0}}) begin
            quot_d  = {N{1'b1}};
            rem_d   = gnt_a_s;
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
`else
          state_d = S_ISSUE;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (div_done) begin
          quot_d  = div_quot;
          rem_d   = div_rem;
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= {PW{1'b0}};
      id_q    <= {ID_W{1'b0}};
      a_q     <= {N{1'b0}};
      b_q     <= {N{1'b0}};
      quot_q  <= {N{1'b0}};
      rem_q   <= {N{1'b0}};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

  // Outputs come straight from flops or from state-flop decodes.
  assign rsp_valid = (state_q == S_RESP);
  assign div_en    = (state_q == S_ISSUE);
  assign rsp_id    = id_q;
  assign rsp_quot  = quot_q;
  assign rsp_rem   = rem_q;
  assign div_a     = a_q;
  assign div_b     = b_q;

endmodule

// File: tb/tb_div_sched.sv
// Randomised and directed bench for div_sched.
// It includes a behavioural divider with random latency.
// A cycle-level reference model tracks the expected grant, div_en, response and pointer.
module tb_div_sched;
  localparam int N    = 21;
  localparam int NREQ = 2;
  localparam int ID_W = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*N-1:0] req_a, req_b;
  logic              rsp_valid, rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic [N-1:0]      rsp_quot, rsp_rem;
  logic              div_en, div_done;
  logic [N-1:0]      div_a, div_b, div_quot, div_rem;

  div_sched #(.N(N), .NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_quot(rsp_quot), .rsp_rem(rsp_rem),
    .div_en(div_en), .div_a(div_a), .div_b(div_b),
    .div_done(div_done), .div_quot(div_quot), .div_rem(div_rem)
  );

  always #5 clk = ~clk;

  // Behavioural divider: random latency and a one-cycle done pulse.
  // For b == 0 it returns quotient all ones and remainder a.
  // Spurious done pulses with junk data are injected while a response is stalled.
  logic [N-1:0] dv_a, dv_b;
  int           dv_cnt;
  logic         dv_busy;
  always @(posedge clk) begin
    if (!rst_n) begin
      dv_busy <= 1'b0; dv_cnt <= 0; div_done <= 1'b0;
      div_quot <= '0; div_rem <= '0; dv_a <= '0; dv_b <= '0;
    end else begin
      div_done <= 1'b0;
      if (div_en) begin
        dv_a <= div_a; dv_b <= div_b; dv_busy <= 1'b1;
        dv_cnt <= $urandom_range(1, 5);
      end else if (dv_busy) begin
        if (dv_cnt == 1) begin
          dv_busy  <= 1'b0;
          div_done <= 1'b1;
          div_quot <= (dv_b == '0) ? {N{1'b1}} : dv_a / dv_b;
          div_rem  <= (dv_b == '0) ? dv_a : dv_a % dv_b;
        end else begin
          dv_cnt <= dv_cnt - 1;
        end
      end else if (rsp_valid && !rsp_ready && ($urandom_range(0, 1) == 1)) begin
        div_done <= 1'b1;
        div_quot <= N'($urandom);
        div_rem  <= N'($urandom);
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model state.
  int           m_ptr;
  bit           m_busy, m_issue, m_wait, m_rsp;
  int           m_id;
  logic [N-1:0] m_a, m_b, m_q, m_r;
  bit           acc;
  int           acc_id;
  int           en_cnt;
  int           grant_q[$];
  int           log_id[$];
  logic [N-1:0] log_q[$], log_r[$];

  task automatic model_reset();
    m_ptr = 0; m_busy = 0; m_issue = 0; m_wait = 0; m_rsp = 0; m_id = 0;
  endtask

  // Called at a falling edge. It drives inputs, checks outputs against the model,
  // advances the model across the next rising edge, and waits for the next falling edge.
  task automatic step(input logic [1:0] v, input logic [N-1:0] a0, input logic [N-1:0] b0,
                      input logic [N-1:0] a1, input logic [N-1:0] b1, input logic rr);
    int g;
    logic [1:0] exp_rdy;
    logic [N-1:0] ga, gb;
    req_valid = v; req_a = {a1, a0}; req_b = {b1, b0}; rsp_ready = rr;
    #1;
    g = -1;
    if (!m_busy) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    exp_rdy = (g >= 0) ? (2'b01 << g) : 2'b00;
    chk("req_ready", req_ready, exp_rdy);
    chk("div_en", div_en, m_issue);
    if (m_issue) begin
      chk("div_a", div_a, m_a);
      chk("div_b", div_b, m_b);
    end
    chk("en_with_done", div_en & div_done, 1'b0);
    chk("rsp_valid", rsp_valid, m_rsp);
    if (m_rsp) begin
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_quot", rsp_quot, m_q);
      chk("rsp_rem", rsp_rem, m_r);
    end
    if (div_en) en_cnt++;
    acc = 0;
    if (g >= 0) begin
      acc = 1; acc_id = g; grant_q.push_back(g);
      ga = (g == 0) ? a0 : a1;
      gb = (g == 0) ? b0 : b1;
      m_ptr = (g + 1) % NREQ; m_busy = 1; m_a = ga; m_b = gb; m_id = g;
`ifdef DIV_SCHED_DIVZERO_BYPASS_EN
      if (gb == '0) begin
        m_rsp = 1; m_q = {N{1'b1}}; m_r = ga;
      end else begin
        m_issue = 1;
      end
`else
      m_issue = 1;
`endif
    end else if (m_issue) begin
      m_issue = 0; m_wait = 1;
    end else if (m_wait) begin
      if (div_done) begin
        m_wait = 0; m_rsp = 1;
        m_q = (m_b == '0) ? {N{1'b1}} : m_a / m_b;
        m_r = (m_b == '0) ? m_a : m_a % m_b;
      end
    end else if (m_rsp && rr) begin
      m_rsp = 0; m_busy = 0;
      log_id.push_back(m_id); log_q.push_back(m_q); log_r.push_back(m_r);
    end
    @(negedge clk);
  endtask

  // Synchronous reset for one cycle. Outputs are checked right after the edge.
  task automatic do_reset();
    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b0;
    @(posedge clk); #1;
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_id", rsp_id, 1'b0);
    chk("rst_rsp_quot", rsp_quot, 21'h0);
    chk("rst_rsp_rem", rsp_rem, 21'h0);
    chk("rst_div_en", div_en, 1'b0);
    chk("rst_div_a", div_a, 21'h0);
    chk("rst_div_b", div_b, 21'h0);
    @(negedge clk);
    rst_n = 1'b1; req_valid = 2'b00;
    model_reset();
  endtask

  // Idle the requesters with the consumer ready until `target` responses are logged.
  task automatic drain(input int target);
    for (int c = 0; c < 60 && log_id.size() < target; c++) step(2'b00, '0, '0, '0, '0, 1'b1);
    chk("resp_count", log_id.size(), target);
  endtask

  initial begin
    logic [1:0] mask;
    int e0, n0, gs;
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    en_cnt = 0; model_reset();
    @(negedge clk);
    do_reset();

    // Contention from reset: both requesters valid, requester 0 goes first.
    mask = 2'b11; e0 = en_cnt;
    for (int c = 0; c < 60 && log_id.size() < 2; c++) begin
      step(mask, 21'd50, 21'd5, 21'd9, 21'd4, 1'b1);
      if (acc) mask[acc_id] = 1'b0;
    end
    chk("cont_count", log_id.size(), 2);
    if (log_id.size() >= 2) begin
      chk("cont_id0", log_id[0], 0); chk("cont_q0", log_q[0], 21'd10); chk("cont_r0", log_r[0], 21'd0);
      chk("cont_id1", log_id[1], 1); chk("cont_q1", log_q[1], 21'd2);  chk("cont_r1", log_r[1], 21'd1);
    end
    chk("cont_en_pulses", en_cnt - e0, 2);

    // Single op: 100 / 7.
    n0 = log_id.size(); e0 = en_cnt;
    step(2'b01, 21'd100, 21'd7, '0, '0, 1'b1);
    drain(n0 + 1);
    if (log_id.size() > n0) begin
      chk("single_id", log_id[n0], 0); chk("single_q", log_q[n0], 21'd14); chk("single_r", log_r[n0], 21'd2);
    end
    chk("single_en_pulses", en_cnt - e0, 1);

    // Backpressure: the response is held for 5 cycles while new requests are pending.
    step(2'b01, 21'd77, 21'd3, '0, '0, 1'b0);
    for (int c = 0; c < 30 && !m_rsp; c++) step(2'b00, '0, '0, '0, '0, 1'b0);
    chk("bp_reached_resp", m_rsp, 1'b1);
    e0 = en_cnt;
    for (int c = 0; c < 5; c++) step(2'b11, 21'd5, 21'd1, 21'd6, 21'd2, 1'b0);
    chk("bp_no_en", en_cnt - e0, 0);
    step(2'b10, 21'd5, 21'd1, 21'd60, 21'd7, 1'b1);
    step(2'b10, 21'd5, 21'd1, 21'd60, 21'd7, 1'b1);
    chk("bp_next_accept", acc, 1'b1);
    chk("bp_next_id", acc_id, 1);
    n0 = log_id.size() + 1;
    drain(n0);

    // Divide by zero.
    n0 = log_id.size(); e0 = en_cnt;
    step(2'b01, 21'h1234, 21'd0, '0, '0, 1'b1);
    drain(n0 + 1);
    if (log_id.size() > n0) begin
      chk("dz_q", log_q[n0], 21'h1FFFFF); chk("dz_r", log_r[n0], 21'h1234);
    end
`ifdef DIV_SCHED_DIVZERO_BYPASS_EN
    chk("dz_en_pulses", en_cnt - e0, 0);
`else
    chk("dz_en_pulses", en_cnt - e0, 1);
`endif

    // Fairness: both requesters permanently valid, so grants must alternate.
    gs = grant_q.size();
    for (int c = 0; c < 80; c++) step(2'b11, 21'd1000, 21'd9, 21'd999, 21'd10, 1'b1);
    chk("fair_enough_grants", (grant_q.size() - gs) >= 4, 1'b1);
    for (int i = gs + 1; i < grant_q.size(); i++) chk("fair_alt", grant_q[i], grant_q[i-1] ^ 1);
    drain(log_id.size() + (m_busy ? 1 : 0));

    // Reset while the divider is busy: no stale response, pointer back to 0.
    step(2'b10, '0, '0, 21'd500, 21'd3, 1'b1);
    for (int c = 0; c < 10 && !m_wait; c++) step(2'b00, '0, '0, '0, '0, 1'b1);
    chk("mid_reached_wait", m_wait, 1'b1);
    n0 = log_id.size();
    do_reset();
    for (int c = 0; c < 8; c++) step(2'b00, '0, '0, '0, '0, 1'b1);
    chk("mid_no_stale", log_id.size(), n0);
    step(2'b11, 21'd1000, 21'd33, 21'd7, 21'd7, 1'b1);
    chk("mid_first_grant", acc_id, 0);
    drain(n0 + 1);
    if (log_id.size() > n0) begin
      chk("mid_q", log_q[n0], 21'd30); chk("mid_r", log_r[n0], 21'd10);
    end

    // Randomised traffic.
    for (int c = 0; c < 1500; c++) begin
      logic [N-1:0] ra0, rb0, ra1, rb1;
      ra0 = N'($urandom); ra1 = N'($urandom);
      rb0 = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom >> $urandom_range(0, 20));
      rb1 = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom >> $urandom_range(0, 20));
      step(2'($urandom), ra0, rb0, ra1, rb1, 1'($urandom_range(0, 3) != 0));
    end
    drain(log_id.size() + (m_busy ? 1 : 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
